par2ser_tx: RTL

- Parallel-to-serial transmitter. It accepts a DATA_W-bit word over a valid/ready handshake and shifts it out one bit per clock with a serial valid and last marker.
- It is the sending end of the single-bit registered serial path that feeds the team's serial-capture flops and serial-to-parallel receivers.
- All outputs are registered. There is one clock domain.

---
 rtl/par2ser_pkg.sv | 5 +
 rtl/par2ser_tx_piso_shreg.sv | 30 +++
 rtl/par2ser_tx.sv | 122 ++++++++++++
 3 files changed

// File: rtl/par2ser_pkg.sv
// Shared types and constants for the parallel-to-serial transmitter.
package par2ser_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} p2s_state_t;
  localparam int GAP_CNT_W = 4;
endpackage

// File: rtl/par2ser_tx_piso_shreg.sv
// Loadable shift register; sout is the register's output-end flop, so it is registered.
module piso_shreg #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         sout
);
  logic [W-1:0] sh_q, sh_d;

  // Zeros fill in from the far end, so the register is empty after W shifts.
  always_comb begin
    sh_d = sh_q;
    if (load)
      sh_d = din;
    else if (shift)
      sh_d = MSB_FIRST ? {sh_q[W-2:0], 1'b0} : {1'b0, sh_q[W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) sh_q <= '0;
    else       sh_q <= sh_d;
  end

  assign sout = MSB_FIRST ? sh_q[W-1] : sh_q[0];
endmodule

// File: rtl/par2ser_tx.sv
// Parallel-to-serial transmitter: valid/ready word in, one bit per clock out, optional idle gap.
module par2ser_tx
  import par2ser_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  output logic              ser_o,
  output logic              ser_valid_o,
  output logic              ser_last_o,
  output logic              busy_o
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    GAP_CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  p2s_state_t           state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 busy_q, busy_d;
  logic                 accept;
  logic                 shift_en;

  assign accept   = (state_q == IDLE) && data_valid_i && ready_q;
  assign shift_en = (state_q == SHIFT);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SHIFT;
          bit_cnt_d = CNT_LOAD;
          ready_d   = 1'b0;
          valid_d   = 1'b1;
          last_d    = 1'b0;
        end
      end
      SHIFT: begin
        // bit_cnt_q == 0 means the final bit is on ser_o this cycle.
        if (bit_cnt_q != '0) begin
          bit_cnt_d = bit_cnt_q - 1'b1;
          last_d    = (bit_cnt_q == CNT_W'(1));
        end else begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d = IDLE;
            ready_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
    end
  end

  piso_shreg #(.W(DATA_W), .MSB_FIRST(MSB_FIRST)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (shift_en),
    .din   (data_i),
    .sout  (ser_o)
  );

  assign data_ready_o = ready_q;
  assign ser_valid_o  = valid_q;
  assign ser_last_o   = last_q;
  assign busy_o       = busy_q;
endmodule
